// File: rtl/circle_cover_scan.sv
// circle_cover_scan: walks a GRID_W x GRID_H lattice one point per cycle.
// Each point is tested against two latched circle centres with det_inside.
// The block counts the lattice points covered by the union of both discs and
// reports the count with a one-cycle done pulse.

// det_inside: combinational test of one lattice point against two centres.
// A point is inside a disc when dx^2 + dy^2 <= RADIUS^2. A point that lies in
// both discs is still reported once.
module det_inside #(
  parameter int RADIUS = 4
) (
  input  logic [3:0] i_px,
  input  logic [3:0] i_py,
  input  logic [3:0] i_c1x,
  input  logic [3:0] i_c1y,
  input  logic [3:0] i_c2x,
  input  logic [3:0] i_c2y,
  output logic       pt_is_in
);
  localparam logic [9:0] R_SQ = 10'(RADIUS * RADIUS);

  // Absolute distance between two 4-bit coordinates, squared (max 225).
  function automatic logic [9:0] sq_dist(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    logic [7:0] sq;
    d  = (a >= b) ? (a - b) : (b - a);
    sq = {4'b0000, d} * {4'b0000, d};
    return {2'b00, sq};
  endfunction

  logic [9:0] w_d1;
  logic [9:0] w_d2;

  // Squared Euclidean distance to each centre, then the union test.
  always_comb begin
    w_d1     = sq_dist(i_px, i_c1x) + sq_dist(i_py, i_c1y);
    w_d2     = sq_dist(i_px, i_c2x) + sq_dist(i_py, i_c2y);
    pt_is_in = (w_d1 <= R_SQ) || (w_d2 <= R_SQ);
  end
endmodule

module circle_cover_scan #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int RADIUS = 4,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       c1x,
  input  logic [3:0]       c1y,
  input  logic [3:0]       c2x,
  input  logic [3:0]       c2y,
  output logic             busy,
  output logic [3:0]       scan_x,
  output logic [3:0]       scan_y,
  output logic             done,
  output logic [CNT_W-1:0] cover_cnt
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

  state_t           r_state;
  logic [3:0]       r_c1x;
  logic [3:0]       r_c1y;
  logic [3:0]       r_c2x;
  logic [3:0]       r_c2y;
  logic [3:0]       r_scan_x;
  logic [3:0]       r_scan_y;
  logic             r_in_q;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cover_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_pt_in;
  logic [CNT_W-1:0] w_acc_next;

  det_inside #(
    .RADIUS(RADIUS)
  ) u_det (
    .i_px    (r_scan_x),
    .i_py    (r_scan_y),
    .i_c1x   (r_c1x),
    .i_c1y   (r_c1y),
    .i_c2x   (r_c2x),
    .i_c2y   (r_c2y),
    .pt_is_in(w_pt_in)
  );

  // Accumulator plus the flag registered one cycle earlier.
  always_comb begin
    w_acc_next = r_acc + {{(CNT_W-1){1'b0}}, r_in_q};
  end

  // Scan sequencer: IDLE -> SCAN (one point per cycle) -> DRAIN -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_c1x       <= 4'd0;
      r_c1y       <= 4'd0;
      r_c2x       <= 4'd0;
      r_c2y       <= 4'd0;
      r_scan_x    <= 4'd0;
      r_scan_y    <= 4'd0;
      r_in_q      <= 1'b0;
      r_acc       <= '0;
      r_cover_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_c1x    <= c1x;
            r_c1y    <= c1y;
            r_c2x    <= c2x;
            r_c2y    <= c2y;
            r_scan_x <= 4'd0;
            r_scan_y <= 4'd0;
            r_in_q   <= 1'b0;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SCAN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          // Flag for the current point is added one cycle later.
          r_in_q <= w_pt_in;
          r_acc  <= w_acc_next;
          if (r_scan_x == X_LAST) begin
            if (r_scan_y == Y_LAST) begin
              // Last point: coordinates stay put through DRAIN and DONE.
              r_state <= ST_DRAIN;
            end else begin
              r_scan_x <= 4'd0;
              r_scan_y <= r_scan_y + 4'd1;
            end
          end else begin
            r_scan_x <= r_scan_x + 4'd1;
          end
        end
        ST_DRAIN: begin
          r_acc       <= w_acc_next;
          r_cover_cnt <= w_acc_next;
          r_in_q      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          // start is not accepted here; IDLE is the first cycle it is sampled.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_in_q  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign scan_x    = r_scan_x;
  assign scan_y    = r_scan_y;
  assign cover_cnt = r_cover_cnt;
endmodule

// File: tb/tb_circle_cover_scan.sv
// Directed bench for circle_cover_scan (16x16 lattice, radius 4).
module tb_circle_cover_scan;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] c1x, c1y, c2x, c2y;
  logic       busy;
  logic [3:0] scan_x, scan_y;
  logic       done;
  logic [8:0] cover_cnt;

  int n_checks;
  int n_errors;

  circle_cover_scan #(
    .GRID_W(16),
    .GRID_H(16),
    .RADIUS(4),
    .CNT_W (9)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .c1x      (c1x),
    .c1y      (c1y),
    .c2x      (c2x),
    .c2y      (c2y),
    .busy     (busy),
    .scan_x   (scan_x),
    .scan_y   (scan_y),
    .done     (done),
    .cover_cnt(cover_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference union count over the 16x16 lattice, radius 4 (dx^2+dy^2 <= 16).
  function automatic int model_cover(input int ax, input int ay, input int bx, input int by);
    int n;
    n = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        if (((x-ax)*(x-ax) + (y-ay)*(y-ay) <= 16) ||
            ((x-bx)*(x-bx) + (y-by)*(y-by) <= 16))
          n++;
      end
    end
    return n;
  endfunction

  // One full scan. poke: extra starts at cycles 5 and 100 with other centres.
  // done_start: hold start high across the DONE->IDLE edge.
  task automatic run_scan(input string tag, input logic [3:0] ax, input logic [3:0] ay,
                          input logic [3:0] bx, input logic [3:0] by, input int exp_cnt,
                          input bit poke, input bit done_start);
    int  lat;
    bit  got_done;
    bit  busy_drop;
    @(negedge clk);
    c1x = ax; c1y = ay; c2x = bx; c2y = by;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; got_done = 1'b0; busy_drop = 1'b0;
    while (!got_done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 20 && !poke) begin
        chk({tag, "_scan_x_c20"}, int'(scan_x), 3);
        chk({tag, "_scan_y_c20"}, int'(scan_y), 1);
      end
      if (done) got_done = 1'b1;
      else if (!busy) busy_drop = 1'b1;
      if (poke && (lat == 5 || lat == 100)) begin
        start = 1'b1; c1x = 4'd1; c1y = 4'd14; c2x = 4'd14; c2y = 4'd1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_latency"}, lat, 258);
    chk({tag, "_count"}, int'(cover_cnt), exp_cnt);
    chk({tag, "_busy_held"}, int'(busy_drop), 0);
    chk({tag, "_busy_at_done"}, int'(busy), 1);
    chk({tag, "_last_x"}, int'(scan_x), 15);
    chk({tag, "_last_y"}, int'(scan_y), 15);
    if (done_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
    chk({tag, "_count_held"}, int'(cover_cnt), exp_cnt);
    if (done_start) begin
      @(negedge clk);
      chk({tag, "_done_edge_start_ignored"}, int'(busy), 0);
    end
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    c1x = 4'd0; c1y = 4'd0; c2x = 4'd0; c2y = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(cover_cnt), 0);
    chk("rst_scan_x", int'(scan_x), 0);
    chk("rst_scan_y", int'(scan_y), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identical centres in the middle: a full radius-4 disc of 49 points.
    run_scan("same_centre", 4'd8, 4'd8, 4'd8, 4'd8, 49, 1'b0, 1'b1);
    // Far-apart discs; each loses its two axis tips that fall off the lattice (47+47).
    run_scan("disjoint", 4'd3, 4'd3, 4'd12, 4'd12, 94, 1'b0, 1'b0);
    // Corner clip: one quadrant including the axes.
    run_scan("corner_same", 4'd0, 4'd0, 4'd0, 4'd0, 17, 1'b0, 1'b0);
    run_scan("corner_opp", 4'd0, 4'd0, 4'd15, 4'd15, 34, 1'b0, 1'b0);
    // Overlapping discs: 49 + 49 - 33 shared points.
    run_scan("overlap", 4'd6, 4'd8, 4'd8, 4'd8, model_cover(6, 8, 8, 8), 1'b0, 1'b0);
    // Starts while busy must not disturb the running scan.
    run_scan("poke_busy", 4'd2, 4'd9, 4'd9, 4'd4, model_cover(2, 9, 9, 4), 1'b1, 1'b0);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    c1x = 4'd3; c1y = 4'd3; c2x = 4'd12; c2y = 4'd12;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 120) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_scan_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_count", int'(cover_cnt), 0);
    chk("async_rst_scan_x", int'(scan_x), 0);
    chk("async_rst_scan_y", int'(scan_y), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("after_reset", 4'd8, 4'd8, 4'd8, 4'd8, 49, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
